// File: rtl/servo_pwm_array.sv
// servo_pwm_array
//   N-channel hobby-servo PWM generator. Each channel keeps a target pulse
//   width. The target is set by an absolute command or nudged by jog inputs.
//   A slewed position chases the target at a bounded rate. A per-frame shadow
//   copy of the position drives the output comparator, so pulse widths only
//   change on frame boundaries.
//
// Ports
//   CLOCK_50   in   1                 system clock
//   rst        in   1                 synchronous, active-high reset
//   jog_up     in   NUM_CH            per-channel increase request (level)
//   jog_dn     in   NUM_CH            per-channel decrease request (level)
//   cmd_valid  in   1                 absolute target command valid
//   cmd_ready  out  1                 command accepted when valid & ready
//   cmd_ch     in   $clog2(NUM_CH)+1  target channel index
//   cmd_pos    in   PW                requested pulse width, clocks
//   servo      out  NUM_CH            registered PWM outputs
//   at_target  out  NUM_CH            registered "position == target" flags
module servo_pwm_array #(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 1_000_000,
  parameter int PMIN      = 50_000,
  parameter int PMAX      = 100_000,
  parameter int CENTER    = 75_000,
  parameter int STEP      = 200,
  parameter int TICK_DIV  = 500_000,
  localparam int PW       = $clog2(FRAME_LEN),
  localparam int CHW      = $clog2(NUM_CH) + 1
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [NUM_CH-1:0] jog_up,
  input  logic [NUM_CH-1:0] jog_dn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic [PW-1:0]     cmd_pos,
  output logic [NUM_CH-1:0] servo,
  output logic [NUM_CH-1:0] at_target
);

  localparam int TW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] P_MIN      = PW'(PMIN);
  localparam logic [PW-1:0] P_MAX      = PW'(PMAX);
  localparam logic [PW-1:0] P_CENTER   = PW'(CENTER);
  localparam logic [PW-1:0] STEP_W     = PW'(STEP);
  localparam logic [PW-1:0] FRAME_LAST = PW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

  if (!(NUM_CH >= 1 && NUM_CH <= 16 && PMIN <= CENTER && CENTER <= PMAX &&
        PMAX < FRAME_LEN && STEP >= 1 && TICK_DIV >= 2)) begin : g_param_check
    $error("servo_pwm_array: illegal parameter combination");
  end

  logic [PW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]     target_q [NUM_CH];
  logic [PW-1:0]     target_d [NUM_CH];
  logic [PW-1:0]     pos_q    [NUM_CH];
  logic [PW-1:0]     pos_d    [NUM_CH];
  logic [PW-1:0]     active_q [NUM_CH];
  logic [PW-1:0]     active_d [NUM_CH];
  logic [NUM_CH-1:0] servo_q, servo_d;
  logic [NUM_CH-1:0] at_target_q, at_target_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic          tick;
  logic          frame_end;
  logic          cmd_fire;
  logic [PW-1:0] cmd_clamped;

  assign tick        = (tick_cnt_q == TICK_LAST);
  assign frame_end   = (frame_cnt_q == FRAME_LAST);
  assign cmd_fire    = cmd_valid && cmd_ready_q;
  assign cmd_clamped = (cmd_pos < P_MIN) ? P_MIN :
                       (cmd_pos > P_MAX) ? P_MAX : cmd_pos;

  always_comb begin
    frame_cnt_d = frame_end ? '0 : frame_cnt_q + PW'(1);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    cmd_ready_d = 1'b1;
    servo_d     = '0;
    at_target_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      target_d[c] = target_q[c];
      pos_d[c]    = pos_q[c];
      active_d[c] = active_q[c];

      // A command to this channel overrides any jog in the same cycle.
      // Saturation compares the remaining headroom before stepping, so
      // the arithmetic can never wrap.
      if (cmd_fire && cmd_ch == CHW'(c)) begin
        target_d[c] = cmd_clamped;
      end else if (tick) begin
        if (jog_up[c] && !jog_dn[c]) begin
          target_d[c] = ((P_MAX - target_q[c]) <= STEP_W) ? P_MAX
                                                          : target_q[c] + STEP_W;
        end else if (jog_dn[c] && !jog_up[c]) begin
          target_d[c] = ((target_q[c] - P_MIN) <= STEP_W) ? P_MIN
                                                          : target_q[c] - STEP_W;
        end
      end

      // Slew chases the target as it stood before this cycle's update.
      if (tick) begin
        if (target_q[c] >= pos_q[c]) begin
          pos_d[c] = ((target_q[c] - pos_q[c]) <= STEP_W) ? target_q[c]
                                                          : pos_q[c] + STEP_W;
        end else begin
          pos_d[c] = ((pos_q[c] - target_q[c]) <= STEP_W) ? target_q[c]
                                                          : pos_q[c] - STEP_W;
        end
      end

      if (frame_end) begin
        active_d[c] = pos_q[c];
      end

      servo_d[c]     = (frame_cnt_q < active_q[c]);
      at_target_d[c] = (pos_q[c] == target_q[c]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      frame_cnt_q <= '0;
      tick_cnt_q  <= '0;
      servo_q     <= '0;
      at_target_q <= '1;
      cmd_ready_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        target_q[c] <= P_CENTER;
        pos_q[c]    <= P_CENTER;
        active_q[c] <= P_CENTER;
      end
    end else begin
      frame_cnt_q <= frame_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      servo_q     <= servo_d;
      at_target_q <= at_target_d;
      cmd_ready_q <= cmd_ready_d;
      for (int c = 0; c < NUM_CH; c++) begin
        target_q[c] <= target_d[c];
        pos_q[c]    <= pos_d[c];
        active_q[c] <= active_d[c];
      end
    end
  end

  assign servo     = servo_q;
  assign at_target = at_target_q;
  assign cmd_ready = cmd_ready_q;

endmodule
